// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: NOP encoding, register-field positions and default reset PC.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST         = 32'h00000013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;

    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;

    function automatic logic [REG_IDX_W-1:0] reg_field(input logic [31:0] inst, input int lsb);
        return inst[lsb +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} pairs with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [31:0]      push_pc_i,
    input  logic [31:0]      push_inst_i,
    input  logic             pop_i,
    output logic [31:0]      head_pc_o,
    output logic [31:0]      head_inst_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             do_push, do_pop;

    // Flush dominates both push and pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= RESET_PC;
                inst_mem_q[i] <= NOP_INST;
            end
        end else if (do_push) begin
            pc_mem_q[wr_ptr_q]   <= push_pc_i;
            inst_mem_q[wr_ptr_q] <= push_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
            count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_pc_o   = pc_mem_q[rd_ptr_q];
    assign head_inst_o = inst_mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order word fetch, instruction buffer, stall and redirect.
// Optional misaligned-redirect fault enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        inst_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_fault_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] buf_cnt;
    logic [31:0]      redirect_target;
    logic [31:0]      head_pc, head_inst;
    logic             fifo_empty, fault_q, credit_ok, req_fire, rsp_push;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_d;

    assign redirect_target = redirect_pc;
    assign fetch_fault_o   = fault_q;

    always_comb begin
        fault_d = fault_q;
        if (redirect_valid)
            fault_d = (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign fault_q         = 1'b0;
`endif

    // Buffered plus outstanding words may never exceed the buffer size, so a response always fits.
    assign credit_ok      = ({1'b0, buf_cnt} + {1'b0, out_cnt_q}) < (CNT_W+1)'(FIFO_DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && !fault_q && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_push       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            // No request can fire during a redirect, so every in-flight word becomes stale.
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_cnt_d = out_cnt_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_push)
                rsp_pc_d = rsp_pc_q + 32'd4;
            if (imem_rsp_valid && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (rsp_push),
        .push_pc_i   (rsp_pc_q),
        .push_inst_i (imem_rsp_data),
        .pop_i       (inst_valid_o && !stall),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst),
        .count_o     (buf_cnt),
        .empty_o     (fifo_empty)
    );

    assign inst_valid_o  = !fifo_empty && !fault_q;
    assign instruction_o = inst_valid_o ? head_inst : NOP_INST;
    assign pc_o          = fault_q ? fetch_pc_q : head_pc;
    assign rs1_o         = reg_field(instruction_o, RS1_LSB);
    assign rs2_o         = reg_field(instruction_o, RS2_LSB);
    assign rd_o          = reg_field(instruction_o, RD_LSB);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table and corner sequences, then randomized traffic
// against a stream-level model (expected PC sequence plus a latency-queued memory).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, inst_valid_o;
    logic [31:0] imem_req_addr, instruction_o, pc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault_o;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instruction_o(instruction_o),
        .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .inst_valid_o(inst_valid_o)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .fetch_fault_o(fetch_fault_o)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { bit rv; logic [31:0] addr; bit iv; logic [31:0] pc; logic [31:0] inst; } vec_t;

    mreq_t       pend[$];
    int          cyc = 0, lat = 1, last_due = 0, consumed = 0;
    int          checks = 0, errors = 0;
    bit          scramble = 0, fault_exp = 0, prev_hold = 0, last_fire = 0, last_rsp = 0;
    logic [31:0] exp_pc = 0, exp_addr = 0, prev_pc = 0, fault_pc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return scramble ? (a * 32'h9E3779B1 + 32'h100) : (a + 32'h100);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, play memory, then check outputs against the stream model.
    task automatic step(input bit s, input bit r, input logic [31:0] t, input bit rdy, input bit rs);
        logic [31:0] w;
        @(negedge clk);
        rst = rs; stall = s; redirect_valid = r; redirect_pc = t; imem_req_ready = rdy;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        if (rs) pend.delete();
        else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        last_rsp = imem_rsp_valid;
        #1;
        if (rs) begin
            exp_pc = 32'h0; exp_addr = 32'h0; fault_exp = 0; prev_hold = 0;
            last_fire = 0; last_due = cyc;
        end else begin
            if (r || fault_exp) check("req_blocked", 32'(imem_req_valid), 32'd0);
            else if (imem_req_valid) check("req_addr", imem_req_addr, exp_addr);
            last_fire = imem_req_valid && rdy;
            if (last_fire) begin
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pend.push_back('{addr: imem_req_addr, due: last_due});
                exp_addr += 32'd4;
                check("outstanding_cap", 32'(pend.size() <= DEPTH), 32'd1);
            end
            if (prev_hold) begin
                check("stall_hold_valid", 32'(inst_valid_o), 32'd1);
                check("stall_hold_pc", pc_o, prev_pc);
            end
            if (inst_valid_o && !s && !r) begin
                w = mem_word(exp_pc);
                check("deq_pc", pc_o, exp_pc);
                check("deq_inst", instruction_o, w);
                check("deq_rs1", 32'(rs1_o), 32'(w[19:15]));
                check("deq_rs2", 32'(rs2_o), 32'(w[24:20]));
                check("deq_rd", 32'(rd_o), 32'(w[11:7]));
                exp_pc += 32'd4;
                consumed++;
            end else if (!inst_valid_o) begin
                check("nop_when_empty", instruction_o, NOP_INST);
            end
            prev_hold = inst_valid_o && s && !r;
            prev_pc   = pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
            check("fault_flag", 32'(fetch_fault_o), 32'(fault_exp));
            if (fault_exp) begin
                check("fault_pc", pc_o, fault_pc);
                check("fault_no_valid", 32'(inst_valid_o), 32'd0);
            end
            if (r) begin
                if (t[1:0] != 2'b00) begin fault_exp = 1; fault_pc = t; end
                else begin fault_exp = 0; exp_pc = t; exp_addr = t; end
            end
`else
            if (r) begin exp_pc = t & 32'hFFFF_FFFC; exp_addr = exp_pc; end
`endif
        end
        cyc++;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            step(0, 0, 32'h0, 1, 0);
            got = inst_valid_o;
        end
        check({name, "_timeout"}, 32'(got), 32'd1);
        if (got) check({name, "_pc"}, pc_o, want_pc);
    endtask

    vec_t        tbl[7];
    logic [31:0] nop;
    int          fires, got_n;

    initial begin
        #1000000;
        $display("FAIL global_timeout cycle %0d", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        tbl[0] = '{1, 32'h0, 0, 32'h0, 32'h0};
        tbl[1] = '{1, 32'h4, 0, 32'h0, 32'h0};
        tbl[2] = '{0, 32'h0, 1, 32'h0, 32'h100};
        tbl[3] = '{1, 32'h8, 1, 32'h4, 32'h104};
        tbl[4] = '{1, 32'hC, 0, 32'h0, 32'h0};
        tbl[5] = '{0, 32'h0, 1, 32'h8, 32'h108};
        tbl[6] = '{1, 32'h10, 1, 32'hC, 32'h10C};

        // Reset state
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        nop = NOP_INST;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", instruction_o, NOP_INST);
        check("rst_pc", pc_o, 32'h0);
        check("rst_rs1", 32'(rs1_o), 32'(nop[19:15]));
        check("rst_rs2", 32'(rs2_o), 32'(nop[24:20]));
        check("rst_rd", 32'(rd_o), 32'(nop[11:7]));

        // Start-up vectors with a 1-cycle, always-ready memory
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 32'h0, 1, 0);
            check("vec_req_valid", 32'(imem_req_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) check("vec_req_addr", imem_req_addr, tbl[i].addr);
            check("vec_inst_valid", 32'(inst_valid_o), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                check("vec_pc", pc_o, tbl[i].pc);
                check("vec_inst", instruction_o, tbl[i].inst);
            end
        end

        // Stall from reset: only the credit's worth of requests may issue
        step(0, 0, 32'h0, 1, 1);
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 32'h0, 1, 0);
            fires += int'(last_fire);
        end
        check("stall_fires", 32'(fires), 32'd2);
        check("stall_head_valid", 32'(inst_valid_o), 32'd1);
        check("stall_head_pc", pc_o, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 1, 0);

        // Redirect with two outstanding requests on a 3-cycle memory
        lat = 3;
        got_n = 0;
        for (int k = 0; k < 20 && got_n == 0; k++) begin
            step(0, 0, 32'h0, 1, 0);
            if (pend.size() == 2) got_n = 1;
        end
        check("two_outstanding_timeout", 32'(got_n), 32'd1);
        step(0, 1, 32'h200, 1, 0);
        wait_valid("redir200", 32'h200);

        // Redirect coinciding with a response and a stall
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 0, 0);
        lat = 1;
        got_n = 0;
        for (int k = 0; k < 20 && got_n == 0; k++) begin
            step(1, 0, 32'h0, 1, 0);
            got_n = int'(last_fire);
        end
        check("fire_timeout", 32'(got_n), 32'd1);
        step(1, 1, 32'h400, 1, 0);
        check("redir_rsp_present", 32'(last_rsp), 32'd1);
        step(0, 0, 32'h0, 1, 0);
        check("redir_flushed", 32'(inst_valid_o), 32'd0);
        wait_valid("redir400", 32'h400);

        // Request held while memory is not ready
        step(0, 1, 32'h0, 1, 0);
        got_n = 0;
        for (int k = 0; k < 20 && got_n == 0; k++) begin
            step(0, 0, 32'h0, 1, 0);
            if (exp_addr == 32'h8) got_n = 1;
        end
        check("reach_addr8_timeout", 32'(got_n), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 0, 0);
            check("hold_addr", imem_req_addr, 32'h8);
        end
        check("hold_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0);

        // Misaligned redirect
        step(0, 1, 32'h202, 1, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 1, 0);
            check("fault_port", 32'(fetch_fault_o), 32'd1);
            check("fault_req_valid", 32'(imem_req_valid), 32'd0);
        end
`else
        wait_valid("align202", 32'h200);
`endif
        step(0, 1, 32'h300, 1, 0);
        wait_valid("redir300", 32'h300);

        // Randomized traffic
        scramble = 1;
        step(0, 0, 32'h0, 1, 1);
        got_n = consumed;
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] t;
            if (i % 100 == 0) lat = int'($urandom_range(1, 3));
            t = $urandom & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
            step($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, t,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end
        check("random_progress", 32'(consumed - got_n > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
